trap_csr_unit: RTL and testbench

Machine-mode CSR and trap-response block for the RISC-X core. It consumes the pipeline controller's trap outputs (`save_pc_id`/`save_pc_ex`, exception cause) and `mret` indication, and updates `mepc`/`mcause`/`mstatus`. It returns the redirect targets (`mtvec` base, `mepc`) to the fetch PC mux. It also serves Zicsr read/modify/write accesses from EX and maintains the `mcycle`/`minstret` counters.

---
 rtl/core_pkg.sv | 33 +++
 rtl/csr_counter64.sv | 20 ++
 rtl/trap_csr_unit.sv | 116 +++++++++++
 tb/tb_trap_csr_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the machine-mode CSR/trap block.
package core_pkg;
  typedef enum logic [1:0] {
    CSR_RW = 2'd0,
    CSR_RS = 2'd1,
    CSR_RC = 2'd2
  } csr_op_t;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam logic [4:0] EXC_CAUSE_INSTR_FAULT = 5'd1;
  localparam logic [4:0] EXC_CAUSE_ILLEGAL     = 5'd2;
  localparam logic [4:0] EXC_CAUSE_BREAKPOINT  = 5'd3;
  localparam logic [4:0] EXC_CAUSE_ECALL_M     = 5'd11;
endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit wrapping counter with separate lo/hi write ports.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);
  logic [63:0] cnt_q, cnt_d;
  // a write to either half freezes the whole counter for that cycle
  always_comb cnt_d = (wr_lo_i || wr_hi_i)
    ? {wr_hi_i ? wdata_i : cnt_q[63:32], wr_lo_i ? wdata_i : cnt_q[31:0]}
    : cnt_q + 64'(inc_i);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/trap_csr_unit.sv
// trap_csr_unit: machine-mode CSRs, trap/mret state updates and redirect targets.
module trap_csr_unit import core_pkg::*; #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] MHARTID     = 32'd0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_1124
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        csr_en_i,
  input  csr_op_t     csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        csr_src_zero_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        save_pc_id_i,
  input  logic        save_pc_ex_i,
  input  logic [31:0] pc_id_i,
  input  logic [31:0] pc_ex_i,
  input  logic [4:0]  exception_cause_i,
  input  logic        is_mret_i,
  input  logic        instr_retired_i,
  output logic [31:0] trap_pc_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);
  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic [63:0] mcycle, minstret;
  logic [31:0] mstatus, rdata, wval, pc_sel;
  logic        impl, ro, wr_try, wr_en, trap;
  assign mstatus = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  always_comb begin
    rdata = '0;
    impl = 1'b1;
    case (csr_addr_i)
      CSR_MSTATUS:  rdata = mstatus;
      CSR_MISA:     rdata = MISA_VAL;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = mtval_q;
      CSR_MHARTID:  rdata = MHARTID;
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata = '0;
      CSR_MCYCLE, CSR_CYCLE:       rdata = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:     rdata = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   rdata = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata = minstret[63:32];
      default:      impl = 1'b0;
    endcase
  end
  // misa lives in the writable address range but is still read-only here
  assign ro = csr_addr_i[11:10] == 2'b11 || csr_addr_i == CSR_MISA;
  assign wr_try = csr_en_i && (csr_op_i == CSR_RW || !csr_src_zero_i);
  assign csr_illegal_o = csr_en_i && (!impl || (wr_try && ro));
  assign trap = save_pc_ex_i || save_pc_id_i;
  assign wr_en = wr_try && !csr_illegal_o && !trap;
  assign wval = csr_op_i == CSR_RW ? csr_wdata_i :
                csr_op_i == CSR_RS ? rdata | csr_wdata_i : rdata & ~csr_wdata_i;
  assign pc_sel = save_pc_ex_i ? pc_ex_i : pc_id_i;
  always_comb begin
    mie_d      = trap ? 1'b0 : is_mret_i ? mpie_q :
                 wr_en && csr_addr_i == CSR_MSTATUS ? wval[MSTATUS_MIE_BIT] : mie_q;
    mpie_d     = trap ? mie_q : is_mret_i ? 1'b1 :
                 wr_en && csr_addr_i == CSR_MSTATUS ? wval[MSTATUS_MPIE_BIT] : mpie_q;
    mepc_d     = trap ? {pc_sel[31:1], 1'b0} :
                 wr_en && csr_addr_i == CSR_MEPC ? {wval[31:1], 1'b0} : mepc_q;
    mcause_d   = trap ? {27'b0, exception_cause_i} :
                 wr_en && csr_addr_i == CSR_MCAUSE ? {wval[31], 26'b0, wval[4:0]} : mcause_q;
    mtval_d    = trap ? '0 : wr_en && csr_addr_i == CSR_MTVAL ? wval : mtval_q;
    mtvec_d    = wr_en && csr_addr_i == CSR_MTVEC ? {wval[31:2], 2'b00} : mtvec_q;
    mscratch_d = wr_en && csr_addr_i == CSR_MSCRATCH ? wval : mscratch_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (1'b1),
    .wr_lo_i (wr_en && csr_addr_i == CSR_MCYCLE),
    .wr_hi_i (wr_en && csr_addr_i == CSR_MCYCLEH),
    .wdata_i (wval),
    .cnt_o   (mcycle)
  );
  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (instr_retired_i),
    .wr_lo_i (wr_en && csr_addr_i == CSR_MINSTRET),
    .wr_hi_i (wr_en && csr_addr_i == CSR_MINSTRETH),
    .wdata_i (wval),
    .cnt_o   (minstret)
  );
  assign csr_rdata_o = rdata;
  assign trap_pc_o = {mtvec_q[31:2], 2'b00};
  assign mepc_o = mepc_q;
  assign mie_o = mie_q;
endmodule

// File: tb/tb_trap_csr_unit.sv
// tb_trap_csr_unit: directed checks of CSR access, trap/mret and counters.
module tb_trap_csr_unit;
  import core_pkg::*;
  logic clk_i = 1'b0, rst_n_i = 1'b0;
  logic csr_en_i = 1'b0, csr_src_zero_i = 1'b0, csr_illegal_o;
  csr_op_t csr_op_i = CSR_RW;
  logic [11:0] csr_addr_i = '0;
  logic [31:0] csr_wdata_i = '0, csr_rdata_o, pc_id_i = '0, pc_ex_i = '0;
  logic save_pc_id_i = 1'b0, save_pc_ex_i = 1'b0, is_mret_i = 1'b0, instr_retired_i = 1'b0;
  logic [4:0] exception_cause_i = '0;
  logic [31:0] trap_pc_o, mepc_o;
  logic mie_o;
  int errors = 0, checks = 0;
  logic [31:0] rd;
  logic ill;

  trap_csr_unit dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .csr_en_i(csr_en_i), .csr_op_i(csr_op_i),
    .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_src_zero_i(csr_src_zero_i),
    .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .save_pc_id_i(save_pc_id_i), .save_pc_ex_i(save_pc_ex_i), .pc_id_i(pc_id_i),
    .pc_ex_i(pc_ex_i), .exception_cause_i(exception_cause_i), .is_mret_i(is_mret_i),
    .instr_retired_i(instr_retired_i), .trap_pc_o(trap_pc_o), .mepc_o(mepc_o), .mie_o(mie_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic csr_write(input csr_op_t op, input logic [11:0] a, input logic [31:0] d);
    csr_en_i = 1'b1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = d; csr_src_zero_i = 1'b0;
    tick();
    csr_en_i = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d, output logic il);
    csr_en_i = 1'b1; csr_op_i = CSR_RS; csr_addr_i = a; csr_wdata_i = '0; csr_src_zero_i = 1'b1;
    #1;
    d = csr_rdata_o; il = csr_illegal_o;
    csr_en_i = 1'b0; csr_src_zero_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (trap_pc_o !== 32'h100) begin errors++; $display("FAIL reset_trap_pc got %h exp %h", trap_pc_o, 32'h100); end
    checks++; if (mepc_o !== 32'h0) begin errors++; $display("FAIL reset_mepc got %h exp 0", mepc_o); end
    checks++; if (mie_o !== 1'b0) begin errors++; $display("FAIL reset_mie got %b exp 0", mie_o); end
    csr_read(CSR_MTVEC, rd, ill);
    checks++; if (rd !== 32'h100) begin errors++; $display("FAIL reset_mtvec got %h exp %h", rd, 32'h100); end
    csr_read(CSR_MSTATUS, rd, ill);
    checks++; if (rd !== 32'h0000_1800) begin errors++; $display("FAIL reset_mstatus got %h exp %h", rd, 32'h1800); end
    csr_read(CSR_MSCRATCH, rd, ill);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mscratch got %h exp 0", rd); end
  endtask

  task automatic test_illegal();
    csr_en_i = 1'b1; csr_op_i = CSR_RW; csr_addr_i = CSR_MISA; csr_wdata_i = 32'h0; csr_src_zero_i = 1'b0;
    #1;
    checks++; if (csr_illegal_o !== 1'b1) begin errors++; $display("FAIL misa_write_illegal got %b exp 1", csr_illegal_o); end
    tick();
    csr_en_i = 1'b0;
    csr_read(CSR_MISA, rd, ill);
    checks++; if (rd !== 32'h4000_1124 || ill !== 1'b0) begin errors++; $display("FAIL misa_unchanged got %h/%b exp 40001124/0", rd, ill); end
    csr_read(12'h7C0, rd, ill);
    checks++; if (ill !== 1'b1) begin errors++; $display("FAIL unimpl_illegal got %b exp 1", ill); end
    csr_en_i = 1'b1; csr_op_i = CSR_RS; csr_addr_i = CSR_MHARTID; csr_wdata_i = 32'h1; csr_src_zero_i = 1'b0;
    #1;
    checks++; if (csr_illegal_o !== 1'b1) begin errors++; $display("FAIL mhartid_write_illegal got %b exp 1", csr_illegal_o); end
    csr_en_i = 1'b0;
    csr_write(CSR_RW, CSR_MSCRATCH, 32'h1);
    csr_en_i = 1'b1; csr_op_i = CSR_RW; csr_addr_i = 12'h7C0; csr_wdata_i = 32'hDEAD;
    tick();
    csr_en_i = 1'b0;
    csr_read(CSR_MSCRATCH, rd, ill);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL illegal_no_state got %h exp 1", rd); end
  endtask

  task automatic test_trap_mret();
    csr_write(CSR_RS, CSR_MSTATUS, 32'h8);
    checks++; if (mie_o !== 1'b1) begin errors++; $display("FAIL rs_sets_mie got %b exp 1", mie_o); end
    save_pc_id_i = 1'b1; pc_id_i = 32'h1234; exception_cause_i = EXC_CAUSE_ILLEGAL;
    #1;
    checks++; if (trap_pc_o !== 32'h100) begin errors++; $display("FAIL trap_pc got %h exp %h", trap_pc_o, 32'h100); end
    tick();
    save_pc_id_i = 1'b0;
    checks++; if (mepc_o !== 32'h1234) begin errors++; $display("FAIL trap_mepc got %h exp %h", mepc_o, 32'h1234); end
    csr_read(CSR_MCAUSE, rd, ill);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL trap_mcause got %h exp 2", rd); end
    csr_read(CSR_MSTATUS, rd, ill);
    checks++; if (rd !== 32'h1880 || mie_o !== 1'b0) begin errors++; $display("FAIL trap_mstatus got %h/%b exp 1880/0", rd, mie_o); end
    is_mret_i = 1'b1;
    tick();
    is_mret_i = 1'b0;
    csr_read(CSR_MSTATUS, rd, ill);
    checks++; if (rd !== 32'h1888 || mie_o !== 1'b1) begin errors++; $display("FAIL mret_mstatus got %h/%b exp 1888/1", rd, mie_o); end
    checks++; if (mepc_o !== 32'h1234) begin errors++; $display("FAIL mret_mepc got %h exp %h", mepc_o, 32'h1234); end
  endtask

  task automatic test_simultaneous();
    csr_write(CSR_RW, CSR_MSCRATCH, 32'h0);
    csr_write(CSR_RW, CSR_MTVAL, 32'h5);
    save_pc_ex_i = 1'b1; save_pc_id_i = 1'b1; pc_ex_i = 32'h80; pc_id_i = 32'h84; exception_cause_i = 5'd11;
    csr_en_i = 1'b1; csr_op_i = CSR_RW; csr_addr_i = CSR_MSCRATCH; csr_wdata_i = 32'hAA;
    tick();
    csr_en_i = 1'b0; save_pc_ex_i = 1'b0; save_pc_id_i = 1'b0;
    checks++; if (mepc_o !== 32'h80) begin errors++; $display("FAIL ex_wins_mepc got %h exp %h", mepc_o, 32'h80); end
    csr_read(CSR_MSCRATCH, rd, ill);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL trap_drops_write got %h exp 0", rd); end
    csr_read(CSR_MTVAL, rd, ill);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL trap_clears_mtval got %h exp 0", rd); end
    csr_read(CSR_MSTATUS, rd, ill);
    checks++; if (rd !== 32'h1880) begin errors++; $display("FAIL trap2_mstatus got %h exp 1880", rd); end
    is_mret_i = 1'b1;
    csr_en_i = 1'b1; csr_op_i = CSR_RW; csr_addr_i = CSR_MSTATUS; csr_wdata_i = 32'h0;
    tick();
    csr_addr_i = CSR_MSCRATCH; csr_wdata_i = 32'h55;
    tick();
    csr_en_i = 1'b0; is_mret_i = 1'b0;
    csr_read(CSR_MSTATUS, rd, ill);
    checks++; if (rd !== 32'h1888) begin errors++; $display("FAIL mret_drops_mstatus got %h exp 1888", rd); end
    csr_read(CSR_MSCRATCH, rd, ill);
    checks++; if (rd !== 32'h55) begin errors++; $display("FAIL mret_other_write got %h exp 55", rd); end
  endtask

  task automatic test_counters();
    csr_write(CSR_RW, CSR_MCYCLEH, 32'h0);
    csr_write(CSR_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
    csr_read(CSR_MCYCLE, rd, ill);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_written got %h exp ffffffff", rd); end
    tick();
    csr_read(CSR_MCYCLE, rd, ill);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mcycle_wrap got %h exp 0", rd); end
    csr_read(CSR_MCYCLEH, rd, ill);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL mcycleh_carry got %h exp 1", rd); end
    csr_read(CSR_CYCLEH, rd, ill);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL cycleh_shadow got %h exp 1", rd); end
    instr_retired_i = 1'b1;
    csr_write(CSR_RW, CSR_MINSTRET, 32'h10);
    instr_retired_i = 1'b0;
    csr_read(CSR_MINSTRET, rd, ill);
    checks++; if (rd !== 32'h10) begin errors++; $display("FAIL minstret_write_wins got %h exp 10", rd); end
    instr_retired_i = 1'b1;
    tick();
    instr_retired_i = 1'b0;
    tick();
    csr_read(CSR_INSTRET, rd, ill);
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL instret_inc got %h exp 11", rd); end
    csr_write(CSR_RW, CSR_MINSTRET, 32'hFFFF_FFFF);
    instr_retired_i = 1'b1;
    tick();
    csr_write(CSR_RW, CSR_MINSTRETH, 32'h7);
    instr_retired_i = 1'b0;
    csr_read(CSR_MINSTRET, rd, ill);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL minstret_lo_hold got %h exp 0", rd); end
    csr_read(CSR_MINSTRETH, rd, ill);
    checks++; if (rd !== 32'h7) begin errors++; $display("FAIL minstreth_write got %h exp 7", rd); end
  endtask

  task automatic test_zero_src();
    csr_write(CSR_RW, CSR_MCYCLE, 32'd100);
    csr_en_i = 1'b1; csr_op_i = CSR_RC; csr_addr_i = CSR_CYCLE; csr_wdata_i = 32'hFFFF_FFFF; csr_src_zero_i = 1'b1;
    #1;
    checks++; if (csr_illegal_o !== 1'b0 || csr_rdata_o !== 32'd100) begin errors++; $display("FAIL rc_zero_cycle got %h/%b exp 64/0", csr_rdata_o, csr_illegal_o); end
    tick();
    csr_en_i = 1'b0; csr_src_zero_i = 1'b0;
    csr_read(CSR_MCYCLE, rd, ill);
    checks++; if (rd !== 32'd101) begin errors++; $display("FAIL rc_zero_nowrite got %h exp 65", rd); end
    csr_write(CSR_RS, CSR_MSTATUS, 32'h8);
    csr_write(CSR_RC, CSR_MSTATUS, 32'h8);
    checks++; if (mie_o !== 1'b0) begin errors++; $display("FAIL rc_clears_mie got %b exp 0", mie_o); end
    csr_write(CSR_RW, CSR_MEPC, 32'h1235);
    csr_read(CSR_MEPC, rd, ill);
    checks++; if (rd !== 32'h1234) begin errors++; $display("FAIL mepc_bit0 got %h exp 1234", rd); end
    csr_write(CSR_RW, CSR_MEPC, 32'h2000);
    is_mret_i = 1'b1;
    #1;
    checks++; if (mepc_o !== 32'h2000) begin errors++; $display("FAIL mepc_fwd_mret got %h exp 2000", mepc_o); end
    tick();
    is_mret_i = 1'b0;
    csr_write(CSR_RW, CSR_MTVEC, 32'h203);
    checks++; if (trap_pc_o !== 32'h200) begin errors++; $display("FAIL mtvec_align got %h exp 200", trap_pc_o); end
    csr_write(CSR_RW, CSR_MCAUSE, 32'hFFFF_FFFF);
    csr_read(CSR_MCAUSE, rd, ill);
    checks++; if (rd !== 32'h8000_001F) begin errors++; $display("FAIL mcause_mask got %h exp 8000001f", rd); end
  endtask

  task automatic test_async_reset();
    csr_write(CSR_RW, CSR_MSCRATCH, 32'h77);
    #2 rst_n_i = 1'b0;
    #1;
    csr_read(CSR_MSCRATCH, rd, ill);
    checks++; if (rd !== 32'h0 || trap_pc_o !== 32'h100) begin errors++; $display("FAIL async_reset got %h/%h exp 0/100", rd, trap_pc_o); end
    tick();
    rst_n_i = 1'b1;
    tick();
  endtask

  initial begin
    tick();
    tick();
    rst_n_i = 1'b1;
    tick();
    test_reset();
    test_illegal();
    test_trap_mret();
    test_simultaneous();
    test_counters();
    test_zero_src();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
